// File: rtl/stream_counter_pkg.sv
// stream_counter_pkg: count mode type and shared wrap/saturate next-count helpers
package stream_counter_pkg;
  typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_t;
  function automatic int unsigned next_count(input int unsigned cnt, input int unsigned step, input int unsigned max, input cnt_mode_t mode);
    int unsigned sum;
    sum = cnt + step;
    return mode == CNT_SAT ? (sum >= max ? max : sum) : (sum > max ? sum - (max + 1) : sum);
  endfunction
  function automatic logic sat_hit(input int unsigned cnt, input int unsigned step, input int unsigned max, input cnt_mode_t mode);
    return mode == CNT_SAT && cnt + step >= max;
  endfunction
endpackage

// File: rtl/frame_idx_counter.sv
// frame_idx_counter: token index within a frame, wrapping after FRAME_LEN-1
module frame_idx_counter #(
  parameter int FRAME_LEN = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_is_last
);
  localparam int IDX_W = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
  logic [IDX_W-1:0] r_idx;
  assign o_is_last = r_idx == IDX_W'(FRAME_LEN - 1);
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_idx <= '0;
    else if (i_clr) r_idx <= '0;
    else if (i_inc) r_idx <= o_is_last ? '0 : r_idx + 1'b1;
endmodule

// File: rtl/stream_counter_gen.sv
// stream_counter_gen: valid/ready counter stream with wrap/saturate, frame marking and backpressure
module stream_counter_gen
  import stream_counter_pkg::*;
#(
  parameter int        DATA_W    = 8,
  parameter int        CNT_MAX   = 255,
  parameter int        STEP      = 1,
  parameter cnt_mode_t MODE      = CNT_WRAP,
  parameter int        FRAME_LEN = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_dv,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_dv,
  output logic              o_last,
  input  logic              i_ready,
  output logic              o_sat
);
  if (CNT_MAX < 1 || CNT_MAX > (1 << DATA_W) - 1) begin : g_bad_max
    $error("CNT_MAX out of range");
  end
  if (STEP < 1 || STEP > CNT_MAX) begin : g_bad_step
    $error("STEP out of range");
  end
  if (FRAME_LEN < 1) begin : g_bad_frame
    $error("FRAME_LEN out of range");
  end
  logic [DATA_W-1:0] r_cnt;
  logic [DATA_W-1:0] w_next;
  logic              w_accept;
  logic              w_is_last;
  logic              w_sat_hit;
  assign o_ready   = !o_dv || i_ready;
  assign w_accept  = i_dv && o_ready && !i_clr;
  assign w_next    = DATA_W'(next_count(32'(r_cnt), STEP, CNT_MAX, MODE));
  assign w_sat_hit = sat_hit(32'(r_cnt), STEP, CNT_MAX, MODE);
  frame_idx_counter #(.FRAME_LEN(FRAME_LEN)) u_frame (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_inc    (w_accept),
    .i_clr    (i_clr),
    .o_is_last(w_is_last)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_cnt  <= '0;
      o_data <= '0;
      o_dv   <= 1'b0;
      o_last <= 1'b0;
      o_sat  <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      o_data <= '0;
      o_dv   <= 1'b0;
      o_last <= 1'b0;
      o_sat  <= 1'b0;
    end else if (w_accept) begin
      r_cnt  <= w_next;
      o_data <= r_cnt;
      o_dv   <= 1'b1;
      o_last <= w_is_last;
      o_sat  <= o_sat || w_sat_hit;
    end else if (o_dv && i_ready) o_dv <= 1'b0;
endmodule

// File: tb/tb_stream_counter_gen.sv
// tb_stream_counter_gen: directed checks of default, wrap and saturate counter instances
module tb_stream_counter_gen;
  import stream_counter_pkg::*;
  logic clk = 0;
  logic rst = 1;
  logic clr = 0;
  logic dv = 0;
  logic rdy = 1;
  logic       a_ready, a_dv, a_last, a_sat;
  logic [7:0] a_data;
  logic       b_ready, b_dv, b_last, b_sat;
  logic [7:0] b_data;
  logic       c_ready, c_dv, c_last, c_sat;
  logic [7:0] c_data;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  stream_counter_gen u_a (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_dv(dv), .o_ready(a_ready),
    .o_data(a_data), .o_dv(a_dv), .o_last(a_last), .i_ready(rdy), .o_sat(a_sat)
  );
  stream_counter_gen #(.CNT_MAX(9), .STEP(4), .MODE(CNT_WRAP)) u_b (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_dv(dv), .o_ready(b_ready),
    .o_data(b_data), .o_dv(b_dv), .o_last(b_last), .i_ready(rdy), .o_sat(b_sat)
  );
  stream_counter_gen #(.CNT_MAX(9), .STEP(4), .MODE(CNT_SAT)) u_c (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_dv(dv), .o_ready(c_ready),
    .o_data(c_data), .o_dv(c_dv), .o_last(c_last), .i_ready(rdy), .o_sat(c_sat)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear();
    dv = 0;
    clr = 1;
    tick();
    clr = 0;
  endtask
  initial begin
    int wrap_exp[6];
    int sat_exp[5];
    wrap_exp = '{0, 4, 8, 2, 6, 0};
    sat_exp  = '{0, 4, 8, 9, 9};
    tick();
    chk("rst_dv", 32'(a_dv), 0);
    chk("rst_data", 32'(a_data), 0);
    chk("rst_last", 32'(a_last), 0);
    chk("rst_sat", 32'(c_sat), 0);
    chk("rst_ready", 32'(a_ready), 1);
    rst = 0;
    dv = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("seq_data%0d", k), 32'(a_data), 32'(k));
      chk($sformatf("seq_dv%0d", k), 32'(a_dv), 1);
      chk($sformatf("seq_last%0d", k), 32'(a_last), 32'(k == 15));
    end
    clear();
    chk("clr_dv", 32'(a_dv), 0);
    chk("clr_sat", 32'(c_sat), 0);
    dv = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("wrap_data%0d", k), 32'(b_data), 32'(wrap_exp[k]));
      if (k < 5) chk($sformatf("sat_data%0d", k), 32'(c_data), 32'(sat_exp[k]));
      if (k < 2) chk($sformatf("sat_lo%0d", k), 32'(c_sat), 0);
      if (k >= 3) chk($sformatf("sat_hi%0d", k), 32'(c_sat), 1);
    end
    dv = 0;
    tick();
    chk("drain_dv", 32'(b_dv), 0);
    chk("drain_ready", 32'(b_ready), 1);
    chk("sat_sticky", 32'(c_sat), 1);
    clear();
    dv = 1;
    for (int k = 0; k < 4; k++) tick();
    chk("bp_pre", 32'(a_data), 3);
    rdy = 0;
    #1;
    chk("bp_ready", 32'(a_ready), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp_hold%0d", k), 32'(a_data), 3);
      chk($sformatf("bp_dv%0d", k), 32'(a_dv), 1);
      chk($sformatf("bp_rdy%0d", k), 32'(a_ready), 0);
    end
    rdy = 1;
    #1;
    chk("bp_release", 32'(a_ready), 1);
    tick();
    chk("bp_next", 32'(a_data), 4);
    for (int k = 0; k < 3; k++) tick();
    chk("clr_pre", 32'(a_data), 7);
    clr = 1;
    tick();
    chk("clr_mid_dv", 32'(a_dv), 0);
    chk("clr_mid_last", 32'(a_last), 0);
    chk("clr_mid_sat", 32'(c_sat), 0);
    clr = 0;
    tick();
    chk("clr_post_data", 32'(a_data), 0);
    chk("clr_post_dv", 32'(a_dv), 1);
    chk("clr_post_sat", 32'(c_sat), 0);
    clear();
    dv = 1;
    for (int k = 0; k < 5; k++) tick();
    chk("arst_pre", 32'(a_data), 4);
    #2;
    rst = 1;
    #1;
    chk("arst_dv", 32'(a_dv), 0);
    chk("arst_data", 32'(a_data), 0);
    chk("arst_b_data", 32'(b_data), 0);
    #2;
    rst = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("arst_seq%0d", k), 32'(a_data), 32'(k));
      chk($sformatf("arst_last%0d", k), 32'(a_last), 32'(k == 15));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
